spi_master_rx: RTL and testbench

SPI_MASTER_RX -- requirements
Module: spi_master_rx

---
 rtl/spi_rx_pkg.sv | 10 +
 rtl/sync_2ff.sv | 14 +
 rtl/spi_master_rx.sv | 78 +++++++
 tb/tb_spi_master_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared state encoding and defaults for the SPI receive master
package spi_rx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    STOP  = 2'd3
  } state_t;
  localparam int DATA_BITS_DEF = 32;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  // two back-to-back flops give metastability time to resolve
  always_ff @(posedge clk) begin
    meta <= rst ? 1'b0 : d;
    q    <= rst ? 1'b0 : meta;
  end
endmodule

// File: rtl/spi_master_rx.sv
// spi_master_rx: CPOL=0 SPI master that receives one DATA_BITS word per request
module spi_master_rx
  import spi_rx_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 not_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  state_t               state, nxt;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] sr;
  logic                 miso_s;
  logic                 cnt_last, bit_last;
  logic                 sclk_d, cs_n_d, not_busy_d, rise, done;
  assign cnt_last = cnt == CW'(CLK_DIV - 1);
  assign bit_last = bit_cnt == BW'(DATA_BITS - 1);
  sync_2ff u_sync (
    .clk(clk),
    .rst(rst),
    .d  (miso),
    .q  (miso_s)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // next-state: each phase lasts CLK_DIV cycles; SHIFT ends after the last bit's low phase
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = ena ? START : IDLE;
      START:   nxt = cnt_last ? SHIFT : START;
      SHIFT:   nxt = (cnt_last && !sclk && bit_last) ? STOP : SHIFT;
      STOP:    nxt = cnt_last ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
  // output decode: next values of the registered outputs; sclk doubles as the SHIFT phase bit
  always_comb begin
    sclk_d     = (nxt == SHIFT) && ((state != SHIFT) || (cnt_last ? !sclk : sclk));
    cs_n_d     = !(nxt == START || nxt == SHIFT);
    not_busy_d = nxt == IDLE;
    rise       = sclk_d && !sclk;
    done       = (state == STOP) && (nxt == IDLE);
  end
  // registered outputs, counters and shift register; sample miso on every sclk rise
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      not_busy <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
    end else begin
      sclk     <= sclk_d;
      cs_n     <= cs_n_d;
      not_busy <= not_busy_d;
      rx_valid <= done;
      cnt      <= (state == IDLE || cnt_last) ? '0 : cnt + CW'(1);
      bit_cnt  <= (state == IDLE) ? '0 : bit_cnt + BW'(state == SHIFT && cnt_last && !sclk && !bit_last);
      if (rise) sr <= {sr[DATA_BITS-2:0], miso_s};
      if (done) rx_data <= sr;
    end
  end
endmodule

// File: tb/tb_spi_master_rx.sv
// tb_spi_master_rx: random and directed stimulus against a cycle-count model of the SPI receiver
module tb_spi_master_rx;
  localparam int CD = 4;
  localparam int DB = 32;
  localparam int TOTAL = (2 * DB + 2) * CD;
  localparam int CS_LOW = CD * (2 * DB + 1);
  logic clk = 0, rst, ena, miso;
  logic sclk, cs_n, not_busy, rx_valid;
  logic [DB-1:0] rx_data;
  int checks = 0, failures = 0, valid_cnt = 0;
  bit chk_on = 0;
  logic [DB-1:0] wq[$];
  logic [DB-1:0] cur_word = '0, sh = '0;
  int m_k = -1;
  logic m_valid = 0;
  logic [DB-1:0] m_data = '0;

  spi_master_rx #(.CLK_DIV(CD), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .ena(ena), .miso(miso), .sclk(sclk), .cs_n(cs_n),
    .not_busy(not_busy), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  // slave: load a word on select fall, present MSB first, advance on each sclk fall
  always @(negedge cs_n) begin
    cur_word = (wq.size() > 0) ? wq.pop_front() : DB'($urandom);
    sh = cur_word;
    #1 miso = sh[DB-1];
  end
  always @(negedge sclk) if (cs_n === 1'b0) begin
    sh = sh << 1;
    #1 miso = sh[DB-1];
  end

  // model: a transfer is just a cycle offset k from its first busy cycle
  always @(posedge clk) begin
    if (rst) begin
      m_k = -1; m_valid = 0; m_data = '0;
    end else begin
      m_valid = 0;
      if (m_k < 0) begin
        if (ena) m_k = 0;
      end else begin
        m_k++;
        if (m_k == TOTAL) begin
          m_k = -1; m_valid = 1; m_data = cur_word;
        end
      end
    end
  end

  function automatic logic [DB+3:0] model_vec();
    logic e_cs, e_sclk, e_nb;
    e_cs   = (m_k < 0) || (m_k >= CS_LOW);
    e_nb   = m_k < 0;
    e_sclk = (m_k >= CD) && (m_k < CS_LOW) && (((m_k - CD) / CD) % 2 == 0);
    return {e_cs, e_sclk, e_nb, m_valid, m_data};
  endfunction

  // per-cycle comparison of every output against the model
  always @(negedge clk) if (chk_on) begin
    logic [DB+3:0] act, exp_v;
    act   = {cs_n, sclk, not_busy, rx_valid, rx_data};
    exp_v = model_vec();
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL cycle_model t=%0t k=%0d got cs_n,sclk,nb,vld,data=%b,%b,%b,%b,%h want %b,%b,%b,%b,%h",
               $time, m_k, act[DB+3], act[DB+2], act[DB+1], act[DB], act[DB-1:0],
               exp_v[DB+3], exp_v[DB+2], exp_v[DB+1], exp_v[DB], exp_v[DB-1:0]);
    end
    if (rx_valid === 1'b1) valid_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got %h want %h", name, act, exp_v);
    end
  endtask

  task automatic run_until_valid(output int c, output int r);
    logic p;
    c = 0; r = 0; p = sclk;
    while (rx_valid !== 1'b1 && c < 600) begin
      @(negedge clk);
      c++;
      if (sclk && !p) r++;
      p = sclk;
    end
  endtask

  initial begin
    int c, r, v0, idle;
    logic [DB-1:0] d1;
    rst = 1; ena = 0; miso = 0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    rst = 0;
    repeat (5) @(negedge clk);
    // reset in the middle of idle
    rst = 1;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {cs_n, sclk, not_busy, rx_valid}, 4'b1010);
    check("reset_data", rx_data, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    // single transfer with a one-cycle ena pulse
    wq.push_back(32'hDEADBEEF);
    ena = 1;
    @(negedge clk);
    ena = 0;
    check("start_not_busy", not_busy, 0);
    check("start_cs_n", cs_n, 0);
    run_until_valid(c, r);
    check("single_latency", c, TOTAL);
    check("single_rises", r, DB);
    check("single_data", rx_data, 32'hDEADBEEF);
    @(negedge clk);
    check("single_pulse_width", rx_valid, 0);
    repeat (5) @(negedge clk);
    // handshake: hold ena until accepted, extra pulses while busy are ignored
    v0 = valid_cnt;
    ena = 1;
    c = 0;
    while (not_busy && c < 10) begin @(negedge clk); c++; end
    ena = 0;
    check("handshake_accept", c, 1);
    for (int i = 0; i < 5; i++) begin
      repeat (20) @(negedge clk);
      ena = 1;
      @(negedge clk);
      ena = 0;
    end
    run_until_valid(c, r);
    repeat (20) @(negedge clk);
    check("handshake_xfers", valid_cnt - v0, 1);
    check("handshake_idle", not_busy, 1);
    // back-to-back with ena held
    wq.push_back(32'hA5A50F0F);
    wq.push_back(32'hFFFFFFFF);
    ena = 1;
    @(negedge clk);
    run_until_valid(c, r);
    d1 = rx_data;
    idle = 0;
    while (not_busy && idle < 5) begin idle++; @(negedge clk); end
    ena = 0;
    check("b2b_idle_cycles", idle, 1);
    run_until_valid(c, r);
    check("b2b_second_latency", c, TOTAL);
    check("b2b_first", d1, 32'hA5A50F0F);
    check("b2b_second", rx_data, 32'hFFFFFFFF);
    repeat (5) @(negedge clk);
    // abort during SHIFT after bit 10
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_pre_data", rx_data, 0);
    wq.push_back(32'h5A5A1234);
    ena = 1;
    @(negedge clk);
    ena = 0;
    begin
      logic p;
      r = 0; c = 0; p = sclk;
      while (r < 11 && c < 300) begin
        @(negedge clk); c++;
        if (sclk && !p) r++;
        p = sclk;
      end
    end
    check("abort_reached_bit10", r, 11);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_cs_n", cs_n, 1);
    check("abort_not_busy", not_busy, 1);
    v0 = valid_cnt;
    repeat (300) @(negedge clk);
    check("abort_no_valid", valid_cnt - v0, 0);
    check("abort_data_held", rx_data, 0);
    wq.push_back(32'h00000001);
    ena = 1;
    @(negedge clk);
    ena = 0;
    run_until_valid(c, r);
    check("after_abort_data", rx_data, 32'h00000001);
    check("after_abort_latency", c, TOTAL);
    // random requests with occasional resets, checked cycle by cycle against the model
    repeat (4000) begin
      @(negedge clk);
      ena = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    ena = 0; rst = 0;
    repeat (300) @(negedge clk);
    check("final_idle", not_busy, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
